mem_access_stage: RTL and testbench

//  MEM-stage data-memory responder: accepts load/store requests from the EX/MEM register, owns the data RAM.

---
 rtl/mem_access_stage.sv | 207 ++++++++++++++++++++
 tb/tb_mem_access_stage.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage.sv
// MEM-stage data-memory responder: owns the data RAM, performs byte/half/word
// loads and stores with a fixed access latency, and reports alignment/range faults.
module mem_access_stage #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        is_load,
  input  logic        is_store,
  input  logic [2:0]  load_type,
  input  logic [2:0]  store_type,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  input  logic [4:0]  rd_in,
  input  logic        misaligned,
  output logic        mem_stall,
  output logic        resp_valid,
  output logic [31:0] load_data,
  output logic [4:0]  rd_out,
  output logic        load_wb,
  output logic        fault
);

  // state | meaning
  // IDLE  | waiting for a load/store; accepts it combinationally (cycle 0)
  // BUSY  | access latency countdown, pipeline held
  // RESP  | one-cycle response; the still-present request is ignored

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY + 1) : 1;
  localparam logic [32:0] ADDR_LIMIT = 33'(DEPTH_WORDS) * 33'd4;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t state, state_next;
  logic [CW-1:0] cnt, cnt_next;
  logic accept, enter_resp, req_fault;

  logic          op_load, op_store, op_fault;
  logic [2:0]    op_type;
  logic [1:0]    op_lane;
  logic [AW-1:0] op_idx;
  logic [31:0]   op_wdata;
  logic [4:0]    op_rd;

  logic          eff_load, eff_store, eff_fault;
  logic [2:0]    eff_type;
  logic [1:0]    eff_lane;
  logic [AW-1:0] eff_idx;
  logic [31:0]   eff_wdata;
  logic [4:0]    eff_rd;

  logic [31:0] ram [DEPTH_WORDS];
  logic [31:0] sel_word, lane_wdata, ext_data;
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;
  logic [3:0]  byte_en;
  logic        load_ok;

  assign req_fault = misaligned || ({1'b0, addr} >= ADDR_LIMIT);

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    accept     = 1'b0;
    enter_resp = 1'b0;
    mem_stall  = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid && (is_load || is_store)) begin
          mem_stall = 1'b1;
          accept    = 1'b1;
          cnt_next  = CW'(LATENCY - 1);
          if (LATENCY == 1 || req_fault) begin
            state_next = RESP;
            enter_resp = 1'b1;
          end else begin
            state_next = BUSY;
          end
        end
      end
      BUSY: begin
        mem_stall = 1'b1;
        cnt_next  = cnt - CW'(1);
        if (cnt == CW'(1)) begin
          state_next = RESP;
          enter_resp = 1'b1;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_load  <= 1'b0;
      op_store <= 1'b0;
      op_fault <= 1'b0;
      op_type  <= '0;
      op_lane  <= '0;
      op_idx   <= '0;
      op_wdata <= '0;
      op_rd    <= '0;
    end else if (accept) begin
      op_load  <= is_load;
      op_store <= is_store && !is_load;
      op_fault <= req_fault;
      op_type  <= is_load ? load_type : store_type;
      op_lane  <= addr[1:0];
      op_idx   <= addr[AW+1:2];
      op_wdata <= store_data;
      op_rd    <= rd_in;
    end
  end

  // A fault (or LATENCY == 1) responds straight from IDLE, before the latch is loaded.
  always_comb begin
    if (state == IDLE) begin
      eff_load  = is_load;
      eff_store = is_store && !is_load;
      eff_fault = req_fault;
      eff_type  = is_load ? load_type : store_type;
      eff_lane  = addr[1:0];
      eff_idx   = addr[AW+1:2];
      eff_wdata = store_data;
      eff_rd    = rd_in;
    end else begin
      eff_load  = op_load;
      eff_store = op_store;
      eff_fault = op_fault;
      eff_type  = op_type;
      eff_lane  = op_lane;
      eff_idx   = op_idx;
      eff_wdata = op_wdata;
      eff_rd    = op_rd;
    end
  end

  always_comb begin
    byte_en    = 4'b1111;
    lane_wdata = eff_wdata;
    case (eff_type)
      3'b000: begin
        byte_en    = 4'b0001 << eff_lane;
        lane_wdata = {4{eff_wdata[7:0]}};
      end
      3'b001: begin
        byte_en    = eff_lane[1] ? 4'b1100 : 4'b0011;
        lane_wdata = {2{eff_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    sel_word = ram[eff_idx];
    sel_byte = sel_word[{eff_lane, 3'b000} +: 8];
    sel_half = eff_lane[1] ? sel_word[31:16] : sel_word[15:0];
    case (eff_type)
      3'b000:  ext_data = {{24{sel_byte[7]}}, sel_byte};
      3'b001:  ext_data = {{16{sel_half[15]}}, sel_half};
      3'b100:  ext_data = {24'd0, sel_byte};
      3'b101:  ext_data = {16'd0, sel_half};
      default: ext_data = sel_word;
    endcase
  end

  // RAM has no reset; a synchronous reset on the commit edge suppresses the write.
  always_ff @(posedge clk) begin
    if (!reset && enter_resp && eff_store && !eff_fault) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en[i]) ram[eff_idx][8*i +: 8] <= lane_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      load_data <= '0;
      rd_out    <= '0;
      fault     <= 1'b0;
      load_ok   <= 1'b0;
    end else if (enter_resp) begin
      fault     <= eff_fault;
      load_ok   <= eff_load && !eff_fault;
      load_data <= (eff_load && !eff_fault) ? ext_data : 32'd0;
      rd_out    <= (eff_load && !eff_fault) ? eff_rd : 5'd0;
    end
  end

  assign resp_valid = (state == RESP);
  assign load_wb    = resp_valid && load_ok;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed + randomized bench for mem_access_stage against a byte-array memory model.
module tb_mem_access_stage;
  localparam int DEPTH = 1024;
  localparam int LAT   = 2;

  logic        clk = 1'b0;
  logic        reset, req_valid, is_load, is_store, misaligned;
  logic [2:0]  load_type, store_type;
  logic [31:0] addr, store_data;
  logic [4:0]  rd_in;
  logic        mem_stall, resp_valid, load_wb, fault;
  logic [31:0] load_data;
  logic [4:0]  rd_out;

  int checks = 0;
  int errors = 0;
  logic [7:0] mdl [DEPTH*4];
  logic [31:0] got;

  always #5 clk = ~clk;

  mem_access_stage #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .is_load(is_load),
    .is_store(is_store), .load_type(load_type), .store_type(store_type),
    .addr(addr), .store_data(store_data), .rd_in(rd_in), .misaligned(misaligned),
    .mem_stall(mem_stall), .resp_valid(resp_valid), .load_data(load_data),
    .rd_out(rd_out), .load_wb(load_wb), .fault(fault)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One full transaction with timing checks; expectations come from the byte model.
  task automatic do_op(input logic ld, input logic st, input logic [2:0] ty,
                       input logic [31:0] a, input logic [31:0] d, input logic [4:0] rd,
                       output logic [31:0] data_out);
    int sz, lat;
    logic mis, f, as_load;
    logic [31:0] exp_data;
    logic [4:0] exp_rd;
    logic [7:0] b;
    logic [15:0] h;
    as_load = ld;
    sz = (ty[1:0] == 2'd0) ? 1 : (ty[1:0] == 2'd1) ? 2 : 4;
    mis = (a % sz) != 0;
    f = mis || (a >= DEPTH*4);
    lat = f ? 1 : LAT;
    exp_data = 32'd0;
    exp_rd = 5'd0;
    if (as_load && !f) begin
      b = mdl[a];
      h = {mdl[a+1], mdl[a]};
      case (ty)
        3'b000: exp_data = 32'($signed(b));
        3'b001: exp_data = 32'($signed(h));
        3'b100: exp_data = {24'd0, b};
        3'b101: exp_data = {16'd0, h};
        default: exp_data = {mdl[a+3], mdl[a+2], mdl[a+1], mdl[a]};
      endcase
      exp_rd = rd;
    end
    @(negedge clk);
    req_valid = 1'b1; is_load = ld; is_store = st;
    load_type = ty; store_type = ty; addr = a; store_data = d;
    rd_in = rd; misaligned = mis;
    #1;
    chk("stall_c0", 32'(mem_stall), 32'd1);
    chk("resp_c0", 32'(resp_valid), 32'd0);
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      chk("stall_busy", 32'(mem_stall), 32'(k < lat));
      chk("resp_timing", 32'(resp_valid), 32'(k == lat));
    end
    chk("fault", 32'(fault), 32'(f));
    chk("load_data", load_data, exp_data);
    chk("rd_out", 32'(rd_out), 32'(exp_rd));
    chk("load_wb", 32'(load_wb), 32'(as_load && !f));
    data_out = load_data;
    if (st && !ld && !f) begin
      for (int i = 0; i < sz; i++) mdl[a+i] = d[8*i +: 8];
    end
    // Request held across the RESP edge must not be re-accepted.
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    #1;
    chk("no_reaccept_stall", 32'(mem_stall), 32'd0);
    chk("no_reaccept_resp", 32'(resp_valid), 32'd0);
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; is_load = 1'b0; is_store = 1'b0;
    load_type = '0; store_type = '0; addr = '0; store_data = '0;
    rd_in = '0; misaligned = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_stall", 32'(mem_stall), 32'd0);
    chk("rst_resp", 32'(resp_valid), 32'd0);
    chk("rst_wb", 32'(load_wb), 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_data", load_data, 32'd0);
    chk("rst_rd", 32'(rd_out), 32'd0);
    reset = 1'b0;

    do_op(0, 1, 3'b010, 32'h10, 32'hDEADBEEF, 5'd0, got);
    do_op(1, 0, 3'b010, 32'h10, 32'h0, 5'd7, got);
    chk("lw_deadbeef", got, 32'hDEADBEEF);

    do_op(0, 1, 3'b010, 32'h20, 32'h00000080, 5'd0, got);
    do_op(1, 0, 3'b000, 32'h20, 32'h0, 5'd3, got);
    chk("lb_sext", got, 32'hFFFFFF80);
    do_op(1, 0, 3'b100, 32'h20, 32'h0, 5'd4, got);
    chk("lbu_zext", got, 32'h00000080);

    do_op(0, 1, 3'b010, 32'h30, 32'h0, 5'd0, got);
    do_op(0, 1, 3'b001, 32'h32, 32'h0000ABCD, 5'd0, got);
    do_op(1, 0, 3'b010, 32'h30, 32'h0, 5'd5, got);
    chk("lw_after_sh", got, 32'hABCD0000);
    do_op(1, 0, 3'b001, 32'h32, 32'h0, 5'd6, got);
    chk("lh_sext", got, 32'hFFFFABCD);

    do_op(1, 0, 3'b010, 32'h12, 32'h0, 5'd9, got);
    do_op(1, 0, 3'b010, 32'h10, 32'h0, 5'd9, got);
    chk("lw_after_misfault", got, 32'hDEADBEEF);

    do_op(0, 1, 3'b010, 32'h0, 32'hA5A5A5A5, 5'd0, got);
    do_op(0, 1, 3'b010, 32'(DEPTH*4 - 4), 32'h5A5A5A5A, 5'd0, got);
    do_op(0, 1, 3'b010, 32'(DEPTH*4), 32'hFFFFFFFF, 5'd0, got);
    do_op(1, 0, 3'b010, 32'h0, 32'h0, 5'd1, got);
    chk("word0_intact", got, 32'hA5A5A5A5);
    do_op(1, 0, 3'b010, 32'(DEPTH*4 - 4), 32'h0, 5'd2, got);
    chk("lastword_intact", got, 32'h5A5A5A5A);

    // Reset during BUSY aborts the store before it commits.
    do_op(0, 1, 3'b010, 32'h40, 32'h11111111, 5'd0, got);
    @(negedge clk);
    req_valid = 1'b1; is_load = 1'b0; is_store = 1'b1; store_type = 3'b010;
    addr = 32'h40; store_data = 32'h12345678; misaligned = 1'b0;
    @(negedge clk);
    chk("abort_busy_stall", 32'(mem_stall), 32'd1);
    reset = 1'b1; req_valid = 1'b0;
    @(negedge clk);
    chk("abort_stall", 32'(mem_stall), 32'd0);
    chk("abort_resp", 32'(resp_valid), 32'd0);
    chk("abort_data", load_data, 32'd0);
    chk("abort_rd", 32'(rd_out), 32'd0);
    chk("abort_wb", 32'(load_wb), 32'd0);
    chk("abort_fault", 32'(fault), 32'd0);
    reset = 1'b0;
    do_op(1, 0, 3'b010, 32'h40, 32'h0, 5'd8, got);
    chk("abort_no_write", got, 32'h11111111);

    // Non-memory instruction: no stall, no response.
    @(negedge clk);
    req_valid = 1'b1; is_load = 1'b0; is_store = 1'b0;
    #1;
    chk("nonmem_stall", 32'(mem_stall), 32'd0);
    @(negedge clk);
    chk("nonmem_resp", 32'(resp_valid), 32'd0);
    req_valid = 1'b0;

    for (int i = 0; i < 16; i++)
      do_op(0, 1, 3'b010, 32'h100 + 32'(4*i), $urandom, 5'd0, got);

    for (int n = 0; n < 60; n++) begin
      int r;
      logic ld, st;
      logic [2:0] ty;
      logic [31:0] a;
      r = int'($urandom_range(0, 9));
      ld = 1'($urandom_range(0, 1));
      st = !ld;
      if (r == 2) begin ld = 1'b1; st = 1'b1; end
      if (ld) begin
        case ($urandom_range(0, 4))
          0: ty = 3'b000; 1: ty = 3'b001; 2: ty = 3'b010; 3: ty = 3'b100;
          default: ty = 3'b101;
        endcase
      end else begin
        ty = 3'($urandom_range(0, 2));
      end
      a = 32'h100 + 32'($urandom_range(0, 60));
      if (r == 1) a = 32'(DEPTH*4) + 32'(4 * $urandom_range(0, 255));
      do_op(ld, st, ty, a, $urandom, 5'($urandom_range(0, 31)), got);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
